// File: rtl/coreriscv_axi4_locking_grant_demux_2.sv
// Routes TileLink grant beats to one of two clients through a single holding
// stage, and keeps an 8-beat data block on one client once its first beat is accepted.
module coreriscv_axi4_locking_grant_demux_2 #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic              io_in_bits_client_id,
  input  logic [1:0]        io_in_bits_client_xact_id,
  input  logic [3:0]        io_in_bits_manager_xact_id,
  input  logic [0:0]        io_in_bits_is_builtin_type,
  input  logic [3:0]        io_in_bits_g_type,
  input  logic [2:0]        io_in_bits_addr_beat,
  input  logic [DATA_W-1:0] io_in_bits_data,
  output logic              io_out_0_valid,
  input  logic              io_out_0_ready,
  output logic [1:0]        io_out_0_bits_client_xact_id,
  output logic [3:0]        io_out_0_bits_manager_xact_id,
  output logic [0:0]        io_out_0_bits_is_builtin_type,
  output logic [3:0]        io_out_0_bits_g_type,
  output logic [2:0]        io_out_0_bits_addr_beat,
  output logic [DATA_W-1:0] io_out_0_bits_data,
  output logic              io_out_1_valid,
  input  logic              io_out_1_ready,
  output logic [1:0]        io_out_1_bits_client_xact_id,
  output logic [3:0]        io_out_1_bits_manager_xact_id,
  output logic [0:0]        io_out_1_bits_is_builtin_type,
  output logic [3:0]        io_out_1_bits_g_type,
  output logic [2:0]        io_out_1_bits_addr_beat,
  output logic [DATA_W-1:0] io_out_1_bits_data,
  output logic              io_locked,
  output logic              io_err
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic                r_lock_dest, w_lock_dest_nxt;
  logic                r_err, w_err_nxt;
  logic                r_full, r_dest;
  logic [1:0]          r_cxid;
  logic [3:0]          r_mxid;
  logic [0:0]          r_builtin;
  logic [3:0]          r_gtype;
  logic [2:0]          r_beat;
  logic [DATA_W-1:0]   r_data;

  logic w_sel_ready, w_accept, w_is_blk, w_route;

  // Only the ready of the output currently holding the beat is ever consulted.
  assign w_sel_ready = r_dest ? io_out_1_ready : io_out_0_ready;
  assign io_in_ready = ~r_full | w_sel_ready;
  assign w_accept    = io_in_valid & io_in_ready;
  assign w_is_blk    = io_in_bits_is_builtin_type[0] & (io_in_bits_g_type == 4'h5);
  assign w_route     = (r_state == ST_LOCKED) ? r_lock_dest : io_in_bits_client_id;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lock_dest_nxt = r_lock_dest;
    w_err_nxt       = r_err;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_blk) begin
            w_state_nxt     = ST_LOCKED;
            w_cnt_nxt       = r_cnt + 3'd1;
            w_lock_dest_nxt = io_in_bits_client_id;
          end
        end
        ST_LOCKED: begin
          // Misrouted or non-block beats still count toward the burst.
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) w_state_nxt = ST_IDLE;
          if ((io_in_bits_client_id != r_lock_dest) || !w_is_blk) w_err_nxt = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_lock_dest <= 1'b0;
      r_err       <= 1'b0;
      r_full      <= 1'b0;
      r_dest      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lock_dest <= w_lock_dest_nxt;
      r_err       <= w_err_nxt;
      r_full      <= w_accept | (r_full & ~w_sel_ready);
      if (w_accept) r_dest <= w_route;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cxid    <= io_in_bits_client_xact_id;
      r_mxid    <= io_in_bits_manager_xact_id;
      r_builtin <= io_in_bits_is_builtin_type;
      r_gtype   <= io_in_bits_g_type;
      r_beat    <= io_in_bits_addr_beat;
      r_data    <= io_in_bits_data;
    end
  end

  assign io_out_0_valid = r_full & ~r_dest;
  assign io_out_1_valid = r_full &  r_dest;

  assign io_out_0_bits_client_xact_id  = r_cxid;
  assign io_out_0_bits_manager_xact_id = r_mxid;
  assign io_out_0_bits_is_builtin_type = r_builtin;
  assign io_out_0_bits_g_type          = r_gtype;
  assign io_out_0_bits_addr_beat       = r_beat;
  assign io_out_0_bits_data            = r_data;
  assign io_out_1_bits_client_xact_id  = r_cxid;
  assign io_out_1_bits_manager_xact_id = r_mxid;
  assign io_out_1_bits_is_builtin_type = r_builtin;
  assign io_out_1_bits_g_type          = r_gtype;
  assign io_out_1_bits_addr_beat       = r_beat;
  assign io_out_1_bits_data            = r_data;

  assign io_locked = (r_state == ST_LOCKED);
  assign io_err    = r_err;

endmodule
